vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_if.sv | 26 ++
 rtl/vga_timing_gen.sv | 90 +++++++++
 tb/tb_vga_timing_gen.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing_gen to the colour stage.
// The generator drives it; consumers only read.
interface vga_timing_if #(
   parameter int FRAME_BITS = 9
);
   logic [9:0]            hpos;
   logic [9:0]            vpos;
   logic                  hsync;
   logic                  vsync;
   logic                  display_on;
   logic                  line_start;
   logic                  frame_start;
   logic [FRAME_BITS-1:0] frame_no;

   modport master (
      output hpos, vpos, hsync, vsync,
      output display_on, line_start,
      output frame_start, frame_no
   );

   modport slave (
      input hpos, vpos, hsync, vsync,
      input display_on, line_start,
      input frame_start, frame_no
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator with frame counter.
// All outputs are registered and describe the same beam position.
module vga_timing_gen #(
   parameter int H_DISPLAY  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_DISPLAY  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_POL   = 0,
   parameter int FRAME_BITS = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   vga_timing_if.master vid
);
   localparam int H_TOTAL =
      H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL =
      V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
   localparam logic [9:0] HS_BEG =
      10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END =
      10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_BEG =
      10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END =
      10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   localparam logic ACT = (SYNC_POL != 0);
   localparam logic [FRAME_BITS-1:0] F_INC =
      FRAME_BITS'(1);

   logic       h_wrap;
   logic       v_wrap;
   logic [9:0] h_nxt;
   logic [9:0] v_nxt;
   logic       hs_nxt;
   logic       vs_nxt;
   logic       de_nxt;

   // Levels are derived from the next position so they
   // land in the same cycle as the counters they describe.
   always_comb begin
      h_wrap = (vid.hpos == H_MAX);
      v_wrap = (vid.vpos == V_MAX);
      h_nxt  = h_wrap ? 10'd0 : vid.hpos + 10'd1;
      v_nxt  = vid.vpos;
      if (h_wrap)
         v_nxt = v_wrap ? 10'd0 : vid.vpos + 10'd1;
      hs_nxt = (h_nxt >= HS_BEG) && (h_nxt <= HS_END);
      vs_nxt = (v_nxt >= VS_BEG) && (v_nxt <= VS_END);
      de_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vid.hpos        <= H_MAX;
         vid.vpos        <= V_MAX;
         vid.hsync       <= ~ACT;
         vid.vsync       <= ~ACT;
         vid.display_on  <= 1'b0;
         vid.line_start  <= 1'b0;
         vid.frame_start <= 1'b0;
         vid.frame_no    <= '1;
      end else begin
         vid.line_start  <= 1'b0;
         vid.frame_start <= 1'b0;
         if (en) begin
            vid.hpos        <= h_nxt;
            vid.vpos        <= v_nxt;
            vid.hsync       <= hs_nxt ? ACT : ~ACT;
            vid.vsync       <= vs_nxt ? ACT : ~ACT;
            vid.display_on  <= de_nxt;
            vid.line_start  <= h_wrap;
            vid.frame_start <= h_wrap && v_wrap;
            if (h_wrap && v_wrap)
               vid.frame_no <= vid.frame_no + F_INC;
         end
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default build plus a tiny
// SYNC_POL=1 build that reaches frame_no wrap quickly.
module tb_vga_timing_gen;
   typedef struct packed {
      logic [9:0] hpos;
      logic [9:0] vpos;
      logic       hs;
      logic       vs;
      logic       de;
      logic       ls;
      logic       fs;
      logic [8:0] fno;
   } obs_t;

   typedef struct {
      logic en;
      obs_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic en_a = 1'b1;
   logic en_b = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;
   int na = 0;
   int nb = 0;
   bit la = 1'b0;
   bit lb = 1'b0;

   vga_timing_if #(.FRAME_BITS(9)) va ();
   vga_timing_if #(.FRAME_BITS(9)) vb ();

   vga_timing_gen dut_a (
      .clk   (clk),
      .reset (rst_a),
      .en    (en_a),
      .vid   (va)
   );

   vga_timing_gen #(
      .H_DISPLAY(4), .H_FRONT(1),
      .H_SYNC(2),    .H_BACK(1),
      .V_DISPLAY(3), .V_FRONT(1),
      .V_SYNC(1),    .V_BACK(1),
      .SYNC_POL(1),  .FRAME_BITS(9)
   ) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .en    (en_b),
      .vid   (vb)
   );

   always #5 clk = ~clk;

   function automatic obs_t get_a();
      return {va.hpos, va.vpos, va.hsync, va.vsync,
              va.display_on, va.line_start,
              va.frame_start, va.frame_no};
   endfunction

   function automatic obs_t get_b();
      return {vb.hpos, vb.vpos, vb.hsync, vb.vsync,
              vb.display_on, vb.line_start,
              vb.frame_start, vb.frame_no};
   endfunction

   // n = enabled edges since reset; position follows by
   // plain division of the raster index.
   function automatic obs_t model(
      input int n, input bit last_en,
      input int hd, input int hf, input int hs,
      input int hb, input int vd, input int vf,
      input int vs, input int vbk, input bit pol
   );
      obs_t o;
      int ht, vt, idx, h, v;
      ht = hd + hf + hs + hb;
      vt = vd + vf + vs + vbk;
      if (n == 0) begin
         o.hpos = 10'(ht - 1);
         o.vpos = 10'(vt - 1);
         o.hs   = ~pol;
         o.vs   = ~pol;
         o.de   = 1'b0;
         o.ls   = 1'b0;
         o.fs   = 1'b0;
         o.fno  = 9'h1ff;
         return o;
      end
      idx = (n - 1) % (ht * vt);
      h = idx % ht;
      v = idx / ht;
      o.hpos = 10'(h);
      o.vpos = 10'(v);
      o.hs = (h >= hd + hf && h < hd + hf + hs)
             ? pol : ~pol;
      o.vs = (v >= vd + vf && v < vd + vf + vs)
             ? pol : ~pol;
      o.de = (h < hd) && (v < vd);
      o.ls = last_en && (h == 0);
      o.fs = last_en && (h == 0) && (v == 0);
      o.fno = 9'(((n - 1) / (ht * vt)) % 512);
      return o;
   endfunction

   function automatic obs_t mod_a();
      return model(na, la, 640, 16, 96, 48,
                   480, 10, 2, 33, 1'b0);
   endfunction

   function automatic obs_t mod_b();
      return model(nb, lb, 4, 1, 2, 1,
                   3, 1, 1, 1, 1'b1);
   endfunction

   task automatic chk(
      input string name,
      input logic [63:0] act,
      input logic [63:0] exp
   );
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h",
                  name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_a) begin
         na += int'(en_a);
         la = en_a;
      end
      if (!rst_b) begin
         nb += int'(en_b);
         lb = en_b;
      end
      #1;
   endtask

   initial begin
      vec_t tbl[7];
      obs_t rst_v;
      obs_t p;
      int last_ls;
      int ls_seen;
      bit saw_wrap;
      int prev_fno;
      rst_v = '{hpos: 10'd799, vpos: 10'd524,
                hs: 1'b1, vs: 1'b1, de: 1'b0,
                ls: 1'b0, fs: 1'b0, fno: 9'd511};
      tbl[0] = '{1'b0, rst_v};
      tbl[1] = '{1'b0, rst_v};
      tbl[2] = '{1'b1, '{10'd0, 10'd0, 1'b1, 1'b1,
                 1'b1, 1'b1, 1'b1, 9'd0}};
      tbl[3] = '{1'b0, '{10'd0, 10'd0, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b0, 9'd0}};
      tbl[4] = '{1'b0, '{10'd0, 10'd0, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b0, 9'd0}};
      tbl[5] = '{1'b1, '{10'd1, 10'd0, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b0, 9'd0}};
      tbl[6] = '{1'b1, '{10'd2, 10'd0, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b0, 9'd0}};

      repeat (3) step();
      chk("reset_a", 64'(get_a()), 64'(rst_v));
      chk("reset_b", 64'(get_b()), 64'(mod_b()));

      rst_a = 1'b0;
      for (int i = 0; i < 7; i++) begin
         en_a = tbl[i].en;
         step();
         chk($sformatf("table[%0d]", i),
             64'(get_a()), 64'(tbl[i].exp));
      end

      // Line timing: three full lines with en held high.
      en_a = 1'b1;
      last_ls = -1;
      ls_seen = 0;
      for (int i = 0; i < 2500; i++) begin
         p = get_a();
         step();
         chk("model_a", 64'(get_a()), 64'(mod_a()));
         if (p.hs && !va.hsync)
            chk("hs_fall", 64'(va.hpos), 64'd656);
         if (!p.hs && va.hsync)
            chk("hs_rise", 64'(va.hpos), 64'd752);
         if (p.de && !va.display_on)
            chk("de_fall", 64'(va.hpos), 64'd640);
         if (va.line_start) begin
            if (last_ls >= 0)
               chk("ls_period", 64'(i - last_ls), 64'd800);
            last_ls = i;
            ls_seen++;
         end
      end
      chk("ls_count", 64'(ls_seen), 64'd3);

      // Tiny build: random enable, mid-frame reset,
      // and enough frames to wrap frame_no.
      rst_b = 1'b0;
      saw_wrap = 1'b0;
      prev_fno = -1;
      for (int i = 0; i < 36000; i++) begin
         if (i == 2000) begin
            rst_b = 1'b1;
            #2;
            nb = 0;
            lb = 1'b0;
            chk("async_rst", 64'(get_b()), 64'(mod_b()));
            repeat (3) step();
            chk("rst_hold", 64'(get_b()), 64'(mod_b()));
            rst_b = 1'b0;
            prev_fno = -1;
         end
         en_b = ($urandom_range(0, 7) != 0);
         step();
         chk("model_b", 64'(get_b()), 64'(mod_b()));
         if (vb.frame_start) begin
            if (prev_fno == 511 && vb.frame_no == 9'd0)
               saw_wrap = 1'b1;
            prev_fno = int'(vb.frame_no);
         end
      end
      chk("fno_wrap", 64'(saw_wrap), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
